// File: rtl/montgomery_pkg.sv
// Shared types and sizing helpers for the Montgomery reduction job sequencer.
package montgomery_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FEED    = 3'd1,
        DRAIN   = 3'd2,
        COLLECT = 3'd3,
        DONE    = 3'd4,
        ABORT   = 3'd5
    } seq_state_t;

    localparam int REGISTER_SIZE_DEF = 32;
    localparam int NUM_BLOCKS_DEF    = 256;
    localparam int R_DEF             = 4096;
    localparam int CONST_BLOCKS      = R_DEF / REGISTER_SIZE_DEF;
    localparam int OUT_BLOCKS        = NUM_BLOCKS_DEF / 2;
    localparam int BRAM_RD_LATENCY   = 2;

    function automatic int idx_width(input int n);
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/wrap_block_counter.sv
// Modulo-MAX block index counter with clear priority over increment.
module wrap_block_counter #(
    parameter int MAX = 4,
    parameter int W   = 2
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         clear_in,
    input  logic         inc_in,
    output logic [W-1:0] count_out
);

    localparam logic [W-1:0] LAST = W'(MAX - 1);

    logic [W-1:0] count_r;

    // index register: clear beats increment, wraps LAST -> 0
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            count_r <= '0;
        end else if (clear_in) begin
            count_r <= '0;
        end else if (inc_in) begin
            count_r <= (count_r == LAST) ? '0 : count_r + 1'b1;
        end else begin
            count_r <= count_r;
        end
    end

    assign count_out = count_r;

endmodule

// File: rtl/montgomery_reduce_sequencer.sv
// Job controller for one Montgomery reducer: streams T from BRAM, tracks k/N
// constant indices, collects the half-width result and reports done/timeout.
module montgomery_reduce_sequencer
    import montgomery_pkg::*;
#(
    parameter int REGISTER_SIZE  = 32,
    parameter int NUM_BLOCKS     = 256,
    parameter int R              = 4096,
    parameter int TIMEOUT_CYCLES = 65536
) (
    input  logic                                     clk_in,
    input  logic                                     rst_in,
    input  logic                                     start_in,
    output logic                                     busy_out,
    output logic                                     T_rd_out,
    output logic [idx_width(NUM_BLOCKS)-1:0]         T_addr_out,
    input  logic [REGISTER_SIZE-1:0]                 T_block_in,
    output logic                                     red_valid_out,
    output logic [REGISTER_SIZE-1:0]                 red_T_block_out,
    input  logic                                     red_consumed_k_in,
    input  logic                                     red_consumed_N_in,
    output logic [idx_width(R/REGISTER_SIZE)-1:0]    k_idx_out,
    output logic [idx_width(R/REGISTER_SIZE)-1:0]    N_idx_out,
    input  logic                                     red_valid_in,
    input  logic [REGISTER_SIZE-1:0]                 red_block_in,
    input  logic                                     red_final_in,
    output logic                                     red_rst_out,
    output logic                                     res_valid_out,
    output logic [REGISTER_SIZE-1:0]                 res_block_out,
    output logic                                     res_last_out,
    output logic                                     done_out,
    output logic                                     timeout_out
);

    localparam int N_CONST = R / REGISTER_SIZE;
    localparam int N_OUT   = NUM_BLOCKS / 2;
    localparam int AW      = idx_width(NUM_BLOCKS);
    localparam int KW      = idx_width(N_CONST);
    localparam int CW      = $clog2(N_OUT + 1);
    localparam int WW      = $clog2(TIMEOUT_CYCLES + 1);
    localparam int L       = BRAM_RD_LATENCY;

    localparam logic [AW-1:0] LAST_ADDR = AW'(NUM_BLOCKS - 1);
    localparam logic [CW-1:0] LAST_RES  = CW'(N_OUT - 1);
    localparam logic [WW-1:0] WD_LIMIT  = WW'(TIMEOUT_CYCLES - 1);
    localparam logic [WW-1:0] WD_START  = WW'(1);

    seq_state_t                state_r, state_s;
    logic                      busy_r, rd_r, done_r, timeout_r;
    logic                      res_valid_r, res_last_r;
    logic [AW-1:0]             addr_r;
    logic [L-1:0]              rd_pipe_r;
    logic [CW-1:0]             res_cnt_r;
    logic [WW-1:0]             wd_r;
    logic [REGISTER_SIZE-1:0]  res_block_r;

    logic accept_s, active_s, collecting_s, res_take_s, last_hit_s, abort_s;
    logic unused_final_s;

    // Completion is counter-driven, so the reducer's own final flag is not consulted.
    assign unused_final_s = red_final_in;

    assign accept_s     = (state_r == IDLE) && start_in;
    assign active_s     = (state_r != IDLE);
    assign collecting_s = (state_r == FEED) || (state_r == DRAIN) || (state_r == COLLECT);
    assign res_take_s   = collecting_s && red_valid_in;
    assign last_hit_s   = res_take_s && (res_cnt_r == LAST_RES);
    // A last result in flight (arriving now or flagged last cycle) outranks the watchdog.
    assign abort_s      = collecting_s && (wd_r >= WD_LIMIT) && !last_hit_s && !res_last_r;

    // next-state decode
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_in) state_s = FEED;
                else          state_s = IDLE;
            end
            FEED: begin
                if (abort_s)                  state_s = ABORT;
                else if (addr_r == LAST_ADDR) state_s = DRAIN;
                else                          state_s = FEED;
            end
            DRAIN: begin
                if (abort_s)                                  state_s = ABORT;
                else if (res_last_r)                          state_s = DONE;
                else if (rd_pipe_r[L-2:0] == '0)              state_s = COLLECT;
                else                                          state_s = DRAIN;
            end
            COLLECT: begin
                if (abort_s)         state_s = ABORT;
                else if (res_last_r) state_s = DONE;
                else                 state_s = COLLECT;
            end
            DONE:    state_s = IDLE;
            ABORT:   state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // state, feed pointer, read-alignment pipe, watchdog and result capture
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_r     <= IDLE;
            busy_r      <= 1'b0;
            rd_r        <= 1'b0;
            done_r      <= 1'b0;
            timeout_r   <= 1'b0;
            addr_r      <= '0;
            rd_pipe_r   <= '0;
            wd_r        <= '0;
            res_cnt_r   <= '0;
            res_valid_r <= 1'b0;
            res_block_r <= '0;
            res_last_r  <= 1'b0;
        end else begin
            state_r   <= state_s;
            busy_r    <= (state_s != IDLE);
            rd_r      <= (state_s == FEED);
            done_r    <= (state_s == DONE);
            timeout_r <= (state_s == ABORT);

            if (accept_s)                                addr_r <= '0;
            else if (state_r == FEED && state_s == FEED) addr_r <= addr_r + 1'b1;
            else                                         addr_r <= addr_r;

            // an abort flushes reads still in flight so the reset reducer sees none
            if (state_s == ABORT) rd_pipe_r <= '0;
            else                  rd_pipe_r <= {rd_pipe_r[L-2:0], rd_r};

            if (accept_s)      wd_r <= WD_START;
            else if (active_s) wd_r <= wd_r + 1'b1;
            else               wd_r <= wd_r;

            if (accept_s)        res_cnt_r <= '0;
            else if (res_take_s) res_cnt_r <= res_cnt_r + 1'b1;
            else                 res_cnt_r <= res_cnt_r;

            res_valid_r <= res_take_s;
            res_block_r <= res_take_s ? red_block_in : '0;
            res_last_r  <= last_hit_s;
        end
    end

    wrap_block_counter #(.MAX(N_CONST), .W(KW)) u_k_idx (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (accept_s),
        .inc_in    (active_s && red_consumed_k_in),
        .count_out (k_idx_out)
    );

    wrap_block_counter #(.MAX(N_CONST), .W(KW)) u_n_idx (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .clear_in  (accept_s),
        .inc_in    (active_s && red_consumed_N_in),
        .count_out (N_idx_out)
    );

    assign busy_out        = busy_r;
    assign T_rd_out        = rd_r;
    assign T_addr_out      = addr_r;
    assign red_valid_out   = rd_pipe_r[L-1];
    assign red_T_block_out = rd_pipe_r[L-1] ? T_block_in : '0;
    assign red_rst_out     = rst_in | timeout_r;
    assign res_valid_out   = res_valid_r;
    assign res_block_out   = res_block_r;
    assign res_last_out    = res_last_r;
    assign done_out        = done_r;
    assign timeout_out     = timeout_r;

endmodule
